// File: rtl/dft_seq_ctrl_if.sv
// Control/status bundle between the sample-capture front end, the DFT
// sequencer and the twiddle/MAC datapath. The master drives the requests;
// the slave (the sequencer) drives the state and index outputs.
interface dft_seq_ctrl_if #(
    parameter int MAX_N = 4096,
    parameter int CNT_W = $clog2(MAX_N)
);
    logic             ce;
    logic             start;
    logic [CNT_W:0]   sample_num;
    logic             abort;
    logic [2:0]       state;
    logic             load_ncompute;
    logic             load_to_cache;
    logic             clear;
    logic [CNT_W-1:0] n_idx;
    logic [CNT_W-1:0] k_idx;
    logic             bin_valid;
    logic             busy;
    logic             done;
    logic             err_len;

    modport master (
        output ce, start, sample_num, abort,
        input  state, load_ncompute, load_to_cache, clear, n_idx, k_idx,
               bin_valid, busy, done, err_len
    );

    modport slave (
        input  ce, start, sample_num, abort,
        output state, load_ncompute, load_to_cache, clear, n_idx, k_idx,
               bin_valid, busy, done, err_len
    );
endinterface

// File: rtl/dft_seq_ctrl.sv
// DFT sequencer: load-to-cache, per-bin accumulator clear and the n x k
// compute loop for a runtime length N, followed by a MAC pipeline flush.
// Optional build macro DFT_SEQ_CONTINUOUS_EN: a legal start seen in DONE
// chains straight into the next LOAD instead of passing through IDLE.
module dft_seq_ctrl #(
    parameter int MAX_N    = 4096,
    parameter int CNT_W    = $clog2(MAX_N),
    parameter int PIPE_LAT = 2
) (
    input logic          clk,
    input logic          rst,
    dft_seq_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_CLEAR   = 3'd2,
        S_COMPUTE = 3'd3,
        S_FLUSH   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [CNT_W:0]   MAX_LEN = (CNT_W+1)'(MAX_N);
    localparam logic [CNT_W:0]   ONE_L   = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]       FL_INIT = 4'(PIPE_LAT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d, k_q, k_d;
    logic [CNT_W:0]   len_q, len_d;
    logic [3:0]       fl_q, fl_d;
    logic             err_q, err_d;

    // Last index is taken at CNT_W+1 bits so N=MAX_N compares cleanly.
    logic [CNT_W:0] last_idx;
    logic           n_last, k_last, len_ok;
    assign last_idx = len_q - ONE_L;
    assign n_last   = ({1'b0, n_q} == last_idx);
    assign k_last   = ({1'b0, k_q} == last_idx);
    assign len_ok   = (bus.sample_num != '0) && (bus.sample_num <= MAX_LEN);

    // State, counters, latched length and sticky length error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            k_q     <= '0;
            len_q   <= '0;
            fl_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            len_q   <= len_d;
            fl_q    <= fl_d;
            err_q   <= err_d;
        end
    end

    // Next-state and counter stepping; ce low leaves every register as is.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        len_d   = len_q;
        fl_d    = fl_q;
        err_d   = err_q;
        if (bus.ce) begin
            if (bus.abort) begin
                state_d = S_IDLE;
                n_d     = '0;
                k_d     = '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start) begin
                            if (len_ok) begin
                                len_d   = bus.sample_num;
                                err_d   = 1'b0;
                                n_d     = '0;
                                k_d     = '0;
                                state_d = S_LOAD;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (n_last) begin
                            n_d     = '0;
                            state_d = S_CLEAR;
                        end else begin
                            n_d = n_q + ONE_C;
                        end
                    end
                    S_CLEAR: state_d = S_COMPUTE;
                    S_COMPUTE: begin
                        if (n_last) begin
                            if (k_last) begin
                                fl_d    = FL_INIT;
                                state_d = S_FLUSH;
                            end else begin
                                k_d     = k_q + ONE_C;
                                n_d     = '0;
                                state_d = S_CLEAR;
                            end
                        end else begin
                            n_d = n_q + ONE_C;
                        end
                    end
                    S_FLUSH: begin
                        if (fl_q == '0) state_d = S_DONE;
                        else            fl_d = fl_q - 4'd1;
                    end
                    S_DONE: begin
                        n_d     = '0;
                        k_d     = '0;
                        state_d = S_IDLE;
`ifdef DFT_SEQ_CONTINUOUS_EN
                        if (bus.start) begin
                            if (len_ok) begin
                                len_d   = bus.sample_num;
                                err_d   = 1'b0;
                                state_d = S_LOAD;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
`endif
                    end
                    default: begin
                        n_d     = '0;
                        k_d     = '0;
                        state_d = S_IDLE;
                    end
                endcase
            end
        end
    end

    // Outputs decode registers only; no input reaches an output combinationally.
    assign bus.state         = state_q;
    assign bus.load_ncompute = (state_q == S_IDLE) || (state_q == S_DONE);
    assign bus.load_to_cache = (state_q == S_LOAD);
    assign bus.clear         = (state_q == S_CLEAR);
    assign bus.n_idx         = n_q;
    assign bus.k_idx         = k_q;
    assign bus.bin_valid     = (state_q == S_COMPUTE) && n_last;
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.done          = (state_q == S_DONE);
    assign bus.err_len       = err_q;

endmodule

// File: tb/tb_dft_seq_ctrl.sv
// Bench for dft_seq_ctrl. The reference expands each accepted run into the
// full list of expected per-cycle (state, n, k, bin_valid) entries and walks
// that list one entry per enabled edge.
module tb_dft_seq_ctrl;
    localparam int MAX_N = 16;
    localparam int CNT_W = 4;
    localparam int PL    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dft_seq_ctrl_if #(.MAX_N(MAX_N), .CNT_W(CNT_W)) bus ();

    dft_seq_ctrl #(.MAX_N(MAX_N), .CNT_W(CNT_W), .PIPE_LAT(PL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int st;
        int n;   // -1: not checked
        int k;   // -1: not checked
        bit bv;
    } ent_t;

    ent_t tr[$];
    bit   m_err = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void build(int len);
        tr.delete();
        for (int n = 0; n < len; n++) tr.push_back('{1, n, 0, 1'b0});
        for (int k = 0; k < len; k++) begin
            tr.push_back('{2, 0, k, 1'b0});
            for (int n = 0; n < len; n++) tr.push_back('{3, n, k, (n == len-1)});
        end
        for (int i = 0; i < PL; i++) tr.push_back('{4, -1, -1, 1'b0});
        tr.push_back('{5, -1, -1, 1'b0});
    endfunction

    function automatic void accept(int sn);
        if (sn >= 1 && sn <= MAX_N) begin
            build(sn);
            m_err = 1'b0;
        end else begin
            m_err = 1'b1;
        end
    endfunction

    function automatic void model_step(bit r, bit c, bit s, int sn, bit a);
        if (r) begin
            tr.delete();
            m_err = 1'b0;
        end else if (c) begin
            if (a) tr.delete();
            else if (tr.size() == 0) begin
                if (s) accept(sn);
            end else if (tr[0].st == 5) begin
                tr.delete();
`ifdef DFT_SEQ_CONTINUOUS_EN
                if (s) accept(sn);
`endif
            end else begin
                void'(tr.pop_front());
            end
        end
    endfunction

    task automatic check_all();
        ent_t e;
        e = (tr.size() != 0) ? tr[0] : '{0, 0, 0, 1'b0};
        chk("state", bus.state, e.st);
        chk("load_ncompute", bus.load_ncompute, (e.st == 0 || e.st == 5));
        chk("load_to_cache", bus.load_to_cache, (e.st == 1));
        chk("clear", bus.clear, (e.st == 2));
        if (e.n >= 0) chk("n_idx", bus.n_idx, e.n);
        if (e.k >= 0) chk("k_idx", bus.k_idx, e.k);
        chk("bin_valid", bus.bin_valid, e.bv);
        chk("busy", bus.busy, (e.st != 0));
        chk("done", bus.done, (e.st == 5));
        chk("err_len", bus.err_len, m_err);
    endtask

    task automatic cyc(bit r, bit c, bit s, int sn, bit a);
        logic [31:0] snv;
        snv            = sn;
        rst            = r;
        bus.ce         = c;
        bus.start      = s;
        bus.sample_num = snv[CNT_W:0];
        bus.abort      = a;
        @(posedge clk);
        model_step(r, c, s, sn, a);
        #1;
        check_all();
    endtask

    // Accept a run of length len, optionally freezing ce for frz cycles the
    // first time COMPUTE reaches n_idx=3; reports edges from accept to done.
    task automatic run(int len, int frz, output int lat, output int nclr, output int nbv);
        int left;
        bit armed, c, pclr, pbv;
        left = 0; armed = (frz > 0); pclr = 0; pbv = 0;
        lat = -1; nclr = 0; nbv = 0;
        cyc(0, 1, 1, len, 0);
        for (int i = 1; i <= 2000; i++) begin
            if (armed && bus.state == 3 && bus.n_idx == 3) begin
                left  = frz;
                armed = 0;
            end
            c = (left == 0);
            if (!c) left--;
            cyc(0, c, 0, 0, 0);
            if (bus.clear && !pclr) nclr++;
            if (bus.bin_valid && !pbv) begin
                chk("bin_k_order", bus.k_idx, nbv);
                nbv++;
            end
            pclr = bus.clear;
            pbv  = bus.bin_valid;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        cyc(0, 1, 0, 0, 0);
    endtask

    initial begin
        int lat, nclr, nbv, idle, guard, len;
        bit found;
        bus.ce = 1'b1; bus.start = 1'b0; bus.sample_num = '0; bus.abort = 1'b0;

        // Reset
        repeat (3) cyc(1, 1, 0, 0, 0);
        chk("rst_state", bus.state, 0);
        chk("rst_lnc", bus.load_ncompute, 1);

        // N=4 basic run
        run(4, 0, lat, nclr, nbv);
        chk("n4_latency", lat, 26);
        chk("n4_clears", nclr, 4);
        chk("n4_bins", nbv, 4);

        // Illegal lengths then a legal N=2
        cyc(0, 1, 1, 0, 0);
        chk("len0_err", bus.err_len, 1);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, MAX_N + 1, 0);
        chk("lenmax1_err", bus.err_len, 1);
        chk("lenmax1_idle", bus.state, 0);
        run(2, 0, lat, nclr, nbv);
        chk("n2_bins", nbv, 2);
        chk("n2_err_cleared", bus.err_len, 0);

        // Boundaries: N=1 and N=MAX_N
        run(1, 0, lat, nclr, nbv);
        chk("n1_latency", lat, 1 + 2 + PL);
        run(MAX_N, 0, lat, nclr, nbv);
        chk("nmax_latency", lat, MAX_N + MAX_N * (MAX_N + 1) + PL);
        chk("nmax_bins", nbv, MAX_N);

        // ce freeze mid-COMPUTE
        run(8, 5, lat, nclr, nbv);
        chk("ce_freeze_latency", lat, 8 + 72 + PL + 5);

        // Abort during bin 2, then abort+start together in IDLE
        cyc(0, 1, 1, 4, 0);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.state == 3 && bus.k_idx == 2) begin
                found = 1;
                break;
            end
            cyc(0, 1, 0, 0, 0);
        end
        chk("abort_reach_k2", found, 1);
        cyc(0, 1, 0, 0, 1);
        chk("abort_state", bus.state, 0);
        chk("abort_k", bus.k_idx, 0);
        nbv = 0;
        repeat (30) begin
            cyc(0, 1, 0, 0, 0);
            if (bus.done) nbv++;
        end
        chk("abort_no_done", nbv, 0);
        cyc(0, 1, 1, 4, 1);
        chk("abort_start_idle", bus.state, 0);

        // Reset mid-run
        cyc(0, 1, 1, 5, 0);
        repeat (9) cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("midrst_state", bus.state, 0);
        chk("midrst_n", bus.n_idx, 0);

        // Start held high with N=1: back-to-back only in continuous builds
        cyc(0, 1, 1, 1, 0);
        idle = 0;
        for (int i = 0; i < 21; i++) begin
            cyc(0, 1, 1, 1, 0);
            if (!bus.busy) idle++;
        end
`ifdef DFT_SEQ_CONTINUOUS_EN
        chk("held_start_idle_gaps", idle, 0);
`else
        chk("held_start_idle_gaps", idle, 3);
`endif
        guard = 0;
        while (tr.size() != 0 && guard < 100) begin
            cyc(0, 1, 0, 0, 0);
            guard++;
        end

        // Randomized runs with ce gaps, start noise, abort and reset
        for (int r = 0; r < 25; r++) begin
            case ($urandom_range(0, 7))
                0:       len = 0;
                1:       len = $urandom_range(MAX_N + 1, 31);
                default: len = $urandom_range(1, MAX_N);
            endcase
            cyc(0, 1, 1, len, 0);
            guard = 0;
            while (tr.size() != 0 && guard < 4000) begin
                bit c, s, a, rr;
                c  = ($urandom_range(0, 3) != 0);
                s  = (tr[0].st != 5) && ($urandom_range(0, 9) == 0);
                a  = ($urandom_range(0, 299) == 0);
                rr = ($urandom_range(0, 499) == 0);
                cyc(rr, c, s, $urandom_range(0, 31), a);
                guard++;
            end
            chk("rnd_run_bound", (guard < 4000), 1);
            repeat ($urandom_range(0, 2)) cyc(0, $urandom_range(0, 1), 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
